err_pattern_gen: RTL and testbench

Sequential error-mask generator for the n-bit error-correction test path. It sits directly upstream of the error-injection stage and drives that stage's `err_in` mask. On each request it builds an N-bit mask with exactly the requested number of distinct set bits, at pseudo-random positions, and hands the mask over with a valid/ready handshake.

---
 rtl/err_pkg.sv | 33 +++
 rtl/err_pattern_gen_lfsr.sv | 38 +++
 rtl/err_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_err_pattern_gen.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/err_pkg.sv
// Shared types and constants for the error-mask generator: FSM states,
// LFSR taps, default seed and a constant-foldable clog2.
package err_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    HOLD = 2'd2
  } err_state_e;

  localparam int LFSR_W = 16;

  // Fibonacci taps, x^16 + x^14 + x^13 + x^11 + 1
  localparam int TAP_A = 15;
  localparam int TAP_B = 13;
  localparam int TAP_C = 12;
  localparam int TAP_D = 10;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  // Width of the error counters; wide enough to hold MAX_ERR = 256.
  localparam int CW = 9;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/err_pattern_gen_lfsr.sv
// 16-bit Fibonacci LFSR that advances only when step is high.
// A zero seed would lock the register up, so it is replaced by the default seed.
module err_lfsr16
  import err_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] init_val;
  logic [LFSR_W-1:0] q_q;
  logic [LFSR_W-1:0] q_d;
  logic              feedback;

  assign init_val = (seed == '0) ? DEFAULT_SEED : seed;
  assign feedback = q_q[TAP_A] ^ q_q[TAP_B] ^ q_q[TAP_C] ^ q_q[TAP_D];

  always_comb begin
    q_d = q_q;
    if (step) begin
      q_d = {q_q[LFSR_W-2:0], feedback};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= init_val;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/err_pattern_gen.sv
// Builds an N-bit error mask with a requested number of distinct set bits at
// LFSR-chosen positions. Define ERR_GEN_STATS_EN to add the pattern_cnt counter.
module err_pattern_gen
  import err_pkg::*;
#(
  parameter int              N       = 8,
  parameter int              MAX_ERR = 3,
  parameter logic [15:0]     SEED    = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   num_err,
  output logic         busy,
  output logic         err_valid,
  input  logic         err_ready,
  output logic [N-1:0] err_out
`ifdef ERR_GEN_STATS_EN
  ,
  output logic [15:0]  pattern_cnt
`endif
);

  localparam int          IW        = clog2(N);
  localparam logic [CW-1:0] MAX_ERR_C = CW'(MAX_ERR);

  err_state_e     state_q, state_d;
  logic [N-1:0]   err_out_q, err_out_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  tgt_q, tgt_d;
  logic           err_valid_q, err_valid_d;
  logic           busy_q, busy_d;

  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_step;
  logic [IW-1:0]     pos;
  logic [N-1:0]      pos_oh;
  logic              pick_ok;
  logic              handshake;
  logic [CW-1:0]     tgt_clamp;

  err_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign pos = lfsr_q[IW-1:0];

  // Positions at or above N decode to no bit at all, so they are rejected naturally.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pos_dec
      assign pos_oh[gi] = (pos == IW'(gi));
    end
  endgenerate

  assign pick_ok   = (|pos_oh) && !(|(pos_oh & err_out_q));
  assign handshake = err_valid_q & err_ready;
  assign tgt_clamp = ({1'b0, num_err} > MAX_ERR_C) ? MAX_ERR_C : {1'b0, num_err};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      err_out_q   <= '0;
      cnt_q       <= '0;
      tgt_q       <= '0;
      err_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_out_q   <= err_out_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      err_valid_q <= err_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    err_out_d = err_out_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_out_d = '0;
          cnt_d     = '0;
          tgt_d     = tgt_clamp;
          state_d   = (tgt_clamp == '0) ? HOLD : PICK;
        end
      end
      PICK: begin
        if (pick_ok) begin
          err_out_d = err_out_q | pos_oh;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_d == tgt_q) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (handshake) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_d      = (state_d != IDLE);
    err_valid_d = (state_d == HOLD);
    lfsr_step   = (state_q == PICK);
  end

  assign busy      = busy_q;
  assign err_valid = err_valid_q;
  assign err_out   = err_out_q;

`ifdef ERR_GEN_STATS_EN
  logic [15:0] pattern_cnt_q, pattern_cnt_d;

  always_comb begin
    pattern_cnt_d = pattern_cnt_q;
    if (handshake) begin
      pattern_cnt_d = pattern_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_cnt_q <= '0;
    end else begin
      pattern_cnt_q <= pattern_cnt_d;
    end
  end

  assign pattern_cnt = pattern_cnt_q;
`endif

endmodule

// File: tb/tb_err_pattern_gen.sv
// Directed bench for err_pattern_gen: an N=8 instance with hand-computed masks
// and an N=5 zero-seed instance checked against an LFSR reference model.
module tb_err_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, start_a, ready_a, busy_a, valid_a;
  logic [7:0] num_a;
  logic [7:0] out_a;
  logic       rst_b_n, start_b, ready_b, busy_b, valid_b;
  logic [7:0] num_b;
  logic [4:0] out_b;
`ifdef ERR_GEN_STATS_EN
  logic [15:0] pcnt_a, pcnt_b;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] m_lfsr;
  int hs_b;

  err_pattern_gen #(.N(8), .MAX_ERR(3), .SEED(16'h0001)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .num_err(num_a),
    .busy(busy_a), .err_valid(valid_a), .err_ready(ready_a), .err_out(out_a)
`ifdef ERR_GEN_STATS_EN
    , .pattern_cnt(pcnt_a)
`endif
  );

  err_pattern_gen #(.N(5), .MAX_ERR(3), .SEED(16'h0000)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .start(start_b), .num_err(num_b),
    .busy(busy_b), .err_valid(valid_b), .err_ready(ready_b), .err_out(out_b)
`ifdef ERR_GEN_STATS_EN
    , .pattern_cnt(pcnt_b)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Request on instance A with err_ready already high; mask and latency are hand-derived.
  task automatic req_a(input logic [7:0] n, input logic [7:0] exp_mask, input int exp_pop,
                       input int exp_lat);
    int lat;
    num_a   = n;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    lat     = 1;
    check("busy_after_start_a", busy_a, 1);
    while (!valid_a && lat < 300) begin
      tick();
      lat++;
    end
    check("latency_a", lat, exp_lat);
    check("mask_a", out_a, exp_mask);
    check("popcount_a", $countones(out_a), exp_pop);
    $display("req A num_err=%0d mask=%02h latency=%0d", n, out_a, lat);
    tick();
    check("valid_one_cycle_a", valid_a, 0);
    check("busy_idle_a", busy_a, 0);
    check("mask_kept_a", out_a, exp_mask);
  endtask

  // Request on instance B, expectations from the LFSR reference model.
  task automatic req_b(input logic [7:0] n);
    logic [7:0] m;
    logic [2:0] pos;
    int tgt, cnt, picks, lat;
    tgt   = (n > 8'd3) ? 3 : int'(n);
    m     = '0;
    cnt   = 0;
    picks = 0;
    while (cnt < tgt) begin
      pos = m_lfsr[2:0];
      if (pos < 3'd5 && ((m >> pos) & 8'd1) == 8'd0) begin
        m = m | (8'd1 << pos);
        cnt++;
      end
      m_lfsr = lfsr_next(m_lfsr);
      picks++;
    end
    num_b   = n;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    lat     = 1;
    while (!valid_b && lat < 500) begin
      tick();
      lat++;
    end
    check("latency_b", lat, 1 + picks);
    check("mask_b", out_b, m[4:0]);
    check("popcount_b", $countones(out_b), tgt);
    check("lfsr_b", dut_b.lfsr_q, m_lfsr);
    $display("req B num_err=%0d mask=%02h latency=%0d", n, out_b, lat);
    tick();
    check("valid_one_cycle_b", valid_b, 0);
    hs_b++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    num_a   = '0;   num_b   = '0;
    ready_a = 1'b1; ready_b = 1'b1;
    hs_b    = 0;
    #12;
    check("rst_out_a", out_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_lfsr_a", dut_a.lfsr_q, 16'h0001);
    check("rst_lfsr_zero_seed_b", dut_b.lfsr_q, 16'hACE1);
`ifdef ERR_GEN_STATS_EN
    check("rst_pcnt_a", pcnt_a, 0);
`endif
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    tick();
    tick();
    check("idle_lfsr_a", dut_a.lfsr_q, 16'h0001);
    check("idle_busy_a", busy_a, 0);

    // LFSR from 0001: pos 1, pos 2 accepted
    req_a(8'd2, 8'h06, 2, 3);
    // zero request: valid one cycle after start, empty mask
    req_a(8'd0, 8'h00, 0, 1);
    // clamped to 3: pos 4, 0, then seven duplicate 0s, then pos 1 (LFSR 0801)
    req_a(8'd9, 8'h13, 3, 11);
    check("lfsr_after_clamp_a", dut_a.lfsr_q, 16'h1002);

    // Consumer stalls for 10 cycles; a start during the stall must be ignored
    ready_a = 1'b0;
    num_a   = 8'd1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    begin
      int lat;
      lat = 1;
      while (!valid_a && lat < 300) begin
        tick();
        lat++;
      end
      check("latency_stall_a", lat, 2);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        start_a = 1'b1;
        num_a   = 8'd3;
      end
      if (i == 5) start_a = 1'b0;
      check("stall_valid_a", valid_a, 1);
      check("stall_mask_a", out_a, 8'h04);
      tick();
    end
    start_a = 1'b0;
    ready_a = 1'b1;
    $display("req A num_err=1 mask=%02h stalled 10 cycles", out_a);
    tick();
    check("stall_release_valid_a", valid_a, 0);
    check("stall_release_busy_a", busy_a, 0);
    check("stall_release_mask_a", out_a, 8'h04);
    tick();
    check("ignored_start_busy_a", busy_a, 0);
    check("ignored_start_lfsr_a", dut_a.lfsr_q, 16'h2005);
`ifdef ERR_GEN_STATS_EN
    check("pcnt_a", pcnt_a, 4);
`endif

    // Instance B: one full request, then abort mid-PICK with an async reset
    m_lfsr = 16'hACE1;
    req_b(8'd2);
    num_b   = 8'd3;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    check("mid_pick_busy_b", busy_b, 1);
    rst_b_n = 1'b0;
    #1;
    check("abort_out_b", out_b, 0);
    check("abort_valid_b", valid_b, 0);
    check("abort_busy_b", busy_b, 0);
    check("abort_lfsr_b", dut_b.lfsr_q, 16'hACE1);
`ifdef ERR_GEN_STATS_EN
    check("abort_pcnt_b", pcnt_b, 0);
`endif
    $display("abort B during PICK");
    #2;
    rst_b_n = 1'b1;
    tick();
    m_lfsr = 16'hACE1;
    hs_b   = 0;
    for (int r = 0; r < 100; r++) begin
      req_b(8'($urandom_range(0, 5)));
    end
`ifdef ERR_GEN_STATS_EN
    check("pcnt_b", pcnt_b, hs_b);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
